sipo_capture_ctrl: RTL and testbench



---
 rtl/sipo_pkg.sv | 22 ++
 rtl/sipo_capture_ctrl_if.sv | 40 ++++
 rtl/sipo_shift_en.sv | 30 +++
 rtl/sipo_capture_ctrl.sv | 114 +++++++++++
 tb/tb_sipo_capture_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sipo_pkg.sv
// Shared types and constants for the SIPO capture sequencer.
// The PAR state is only reachable when SIPO_CAPTURE_CTRL_PARITY_EN is defined.
package sipo_pkg;

    localparam int WIDTH_DEF = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        PAR   = 2'd3
    } state_e;

    // Bits needed to count 0..width inclusive, i.e. clog2(width+1).
    function automatic int cnt_w(input int width);
        int r;
        r = 0;
        for (int v = width; v > 0; v = v >> 1) r++;
        return r;
    endfunction

endpackage

// File: rtl/sipo_capture_ctrl_if.sv
// Handshake and data bundle between the serial source/parallel consumer and the
// capture sequencer; parity_err exists only with SIPO_CAPTURE_CTRL_PARITY_EN.
interface sipo_capture_ctrl_if
    import sipo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) ();

    // Handshake: a word transfers on a clock edge where word_valid and
    // out_ready are both high; while word_valid is high without out_ready,
    // word (and parity_err) are held stable and word_valid does not drop.
    logic             start;
    logic             sdi;
    logic             out_ready;
    logic [WIDTH-1:0] word;
    logic             word_valid;
    logic             busy;
    logic             start_drop;
`ifdef SIPO_CAPTURE_CTRL_PARITY_EN
    logic             parity_err;
`endif
    state_e           dbg_state;

    modport master (
        output start, sdi, out_ready,
`ifdef SIPO_CAPTURE_CTRL_PARITY_EN
        input  parity_err,
`endif
        input  word, word_valid, busy, start_drop, dbg_state
    );

    modport slave (
        input  start, sdi, out_ready,
`ifdef SIPO_CAPTURE_CTRL_PARITY_EN
        output parity_err,
`endif
        output word, word_valid, busy, start_drop, dbg_state
    );

endinterface

// File: rtl/sipo_shift_en.sv
// WIDTH-bit serial-in/parallel-out register with shift enable; new bits enter
// at the MSB and move toward bit 0, so the first bit received ends in bit 0.
module sipo_shift_en
    import sipo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             sdi,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (shift_en) sr_d = {sdi, sr_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sr_q <= '0;
        else        sr_q <= sr_d;
    end

    assign q = sr_q;

endmodule

// File: rtl/sipo_capture_ctrl.sv
// Sequencer that clocks exactly WIDTH serial bits into a SIPO and offers the
// result on a valid/ready handshake. Optional parity: SIPO_CAPTURE_CTRL_PARITY_EN.
module sipo_capture_ctrl
    import sipo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                clk,
    input  logic                reset,
    sipo_capture_ctrl_if.slave  bus
);

    localparam int               CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             drop_q, drop_d;
    logic             shift_en;
    logic [WIDTH-1:0] sr_word;
`ifdef SIPO_CAPTURE_CTRL_PARITY_EN
    logic             perr_q, perr_d;
`endif

    sipo_shift_en #(.WIDTH(WIDTH)) u_sr (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en),
        .sdi      (bus.sdi),
        .q        (sr_word)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        drop_d   = drop_q;
        shift_en = 1'b0;
`ifdef SIPO_CAPTURE_CTRL_PARITY_EN
        perr_d   = perr_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (bus.start) drop_d = 1'b1;
                if (cnt_q == LAST) begin
`ifdef SIPO_CAPTURE_CTRL_PARITY_EN
                    state_d = PAR;
`else
                    state_d = HOLD;
`endif
                end
            end
`ifdef SIPO_CAPTURE_CTRL_PARITY_EN
            PAR: begin
                // Even parity: data bits plus parity bit must XOR to zero.
                perr_d  = (^sr_word) ^ bus.sdi;
                state_d = HOLD;
                if (bus.start) drop_d = 1'b1;
            end
`endif
            HOLD: begin
                if (bus.out_ready) begin
`ifdef SIPO_CAPTURE_CTRL_PARITY_EN
                    perr_d = 1'b0;
`endif
                    if (bus.start) begin
                        state_d = SHIFT;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (bus.start) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

`ifdef SIPO_CAPTURE_CTRL_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) perr_q <= 1'b0;
        else        perr_q <= perr_d;
    end
    assign bus.parity_err = perr_q;
`endif

    // The SIPO only moves in SHIFT, so its contents are the frozen word in HOLD.
    assign bus.word       = sr_word;
    assign bus.word_valid = (state_q == HOLD);
    assign bus.busy       = (state_q == SHIFT) || (state_q == PAR);
    assign bus.start_drop = drop_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_sipo_capture_ctrl.sv
// Self-checking bench for sipo_capture_ctrl; also builds with
// SIPO_CAPTURE_CTRL_PARITY_EN defined to cover the parity state.
module tb_sipo_capture_ctrl;
    import sipo_pkg::*;

    localparam int WIDTH = WIDTH_DEF;
`ifdef SIPO_CAPTURE_CTRL_PARITY_EN
    localparam int LAT = WIDTH + 1;
`else
    localparam int LAT = WIDTH;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;

    sipo_capture_ctrl_if #(.WIDTH(WIDTH)) bus ();

    sipo_capture_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int               checks   = 0;
    int               failures = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic             exp_perr_q[$];
    logic             exp_drop = 1'b0;
    logic [WIDTH-1:0] last_word = '0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        checks++;
        if (bus.busy !== 1'b0 || bus.word_valid !== 1'b0 || bus.dbg_state !== IDLE) begin
            failures++;
            $display("FAIL idle_before_start: busy=%b valid=%b state=%0d expected busy=0 valid=0 state=IDLE",
                     bus.busy, bus.word_valid, bus.dbg_state);
        end
        bus.start = 1'b1;
        bus.sdi   = $urandom_range(0, 1);
        step();
        bus.start = 1'b0;
    endtask

    // Drives the LAT serial cycles after an accepted start; drop_at >= 0 pulses
    // start on that shift cycle, which must be ignored and flagged.
    task automatic shift_bits(input logic [WIDTH-1:0] data, input logic par, input int drop_at);
        for (int i = 0; i < LAT; i++) begin
            checks++;
            if (bus.busy !== 1'b1 || bus.word_valid !== 1'b0) begin
                failures++;
                $display("FAIL shift_flags: cycle %0d busy=%b valid=%b expected busy=1 valid=0",
                         i, bus.busy, bus.word_valid);
            end
            bus.sdi   = (i < WIDTH) ? data[i] : par;
            bus.start = (i == drop_at);
            if (i == drop_at) exp_drop = 1'b1;
            step();
        end
        bus.start = 1'b0;
        exp_q.push_back(data);
        exp_perr_q.push_back((^data) ^ par);
    endtask

    // Holds the word for `delay` cycles without out_ready, then hands it off;
    // chain=1 raises start on the handshake edge for a back-to-back capture.
    task automatic hold_and_accept(input int delay, input logic chain, input bit noise);
        for (int i = 0; i <= delay; i++) begin
            checks++;
            if (bus.word_valid !== 1'b1 || bus.busy !== 1'b0 || bus.word !== exp_q[0]) begin
                failures++;
                $display("FAIL hold_word: cycle %0d valid=%b busy=%b word=%h expected valid=1 busy=0 word=%h",
                         i, bus.word_valid, bus.busy, bus.word, exp_q[0]);
            end
`ifdef SIPO_CAPTURE_CTRL_PARITY_EN
            checks++;
            if (bus.parity_err !== exp_perr_q[0]) begin
                failures++;
                $display("FAIL hold_parity: got %b expected %b", bus.parity_err, exp_perr_q[0]);
            end
`endif
            checks++;
            if (bus.start_drop !== exp_drop) begin
                failures++;
                $display("FAIL hold_drop: got %b expected %b", bus.start_drop, exp_drop);
            end
            bus.sdi = $urandom_range(0, 1);
            if (i < delay) begin
                bus.out_ready = 1'b0;
                bus.start     = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
                if (bus.start) exp_drop = 1'b1;
            end else begin
                bus.out_ready = 1'b1;
                bus.start     = chain;
            end
            step();
        end
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        last_word     = exp_q.pop_front();
        void'(exp_perr_q.pop_front());
        if (!chain) begin
            checks++;
            if (bus.word_valid !== 1'b0 || bus.busy !== 1'b0 || bus.dbg_state !== IDLE ||
                bus.word !== last_word) begin
                failures++;
                $display("FAIL after_handshake: valid=%b busy=%b state=%0d word=%h expected 0 0 IDLE %h",
                         bus.word_valid, bus.busy, bus.dbg_state, bus.word, last_word);
            end
`ifdef SIPO_CAPTURE_CTRL_PARITY_EN
            checks++;
            if (bus.parity_err !== 1'b0) begin
                failures++;
                $display("FAIL parity_cleared: got %b expected 0", bus.parity_err);
            end
`endif
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.sdi = 1'b0; bus.out_ready = 1'b0;
        reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        repeat (10) step();
        checks++;
        if (bus.word !== '0 || bus.word_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.start_drop !== 1'b0 || bus.dbg_state !== IDLE) begin
            failures++;
            $display("FAIL reset_state: word=%h valid=%b busy=%b drop=%b state=%0d expected all zero/IDLE",
                     bus.word, bus.word_valid, bus.busy, bus.start_drop, bus.dbg_state);
        end
`ifdef SIPO_CAPTURE_CTRL_PARITY_EN
        checks++;
        if (bus.parity_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_parity: got %b expected 0", bus.parity_err);
        end
`endif
    endtask

    task automatic test_single_word();
        do_start();
        shift_bits(5'b10110, 1'b1, -1);
        hold_and_accept(0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        do_start();
        shift_bits(5'b10110, 1'b0, -1);
        hold_and_accept(7, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_start();
        shift_bits(5'b10110, 1'b1, -1);
        hold_and_accept(0, 1'b1, 1'b0);
        shift_bits(5'b11111, 1'b1, -1);
        hold_and_accept(1, 1'b0, 1'b0);
    endtask

    task automatic test_dropped_start();
        do_start();
        shift_bits(5'b01101, 1'b1, 2);
        hold_and_accept(2, 1'b0, 1'b0);
        repeat (4) step();
        checks++;
        if (bus.start_drop !== 1'b1) begin
            failures++;
            $display("FAIL drop_sticky: got %b expected 1", bus.start_drop);
        end
    endtask

    task automatic test_reset_mid_shift();
        do_start();
        for (int i = 0; i < 3; i++) begin
            bus.sdi = 1'b1;
            step();
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (bus.word !== '0 || bus.word_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.start_drop !== 1'b0 || bus.dbg_state !== IDLE) begin
            failures++;
            $display("FAIL async_reset: word=%h valid=%b busy=%b drop=%b state=%0d expected all zero/IDLE",
                     bus.word, bus.word_valid, bus.busy, bus.start_drop, bus.dbg_state);
        end
        exp_drop = 1'b0;
        exp_q.delete();
        exp_perr_q.delete();
        step();
        reset = 1'b1;
        step();
        do_start();
        shift_bits(5'b00001, 1'b0, -1);
        hold_and_accept(0, 1'b0, 1'b0);
        do_start();
        shift_bits(5'b00001, 1'b1, -1);
        hold_and_accept(0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic chain;
        chain = 1'b0;
        for (int n = 0; n < 24; n++) begin
            logic [WIDTH-1:0] data;
            logic             par;
            int               drop_at;
            int               delay;
            logic             next_chain;
            data       = WIDTH'($urandom);
            par        = $urandom_range(0, 1);
            drop_at    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LAT - 1)) : -1;
            delay      = $urandom_range(0, 4);
            next_chain = (n < 23) ? logic'($urandom_range(0, 1)) : 1'b0;
            if (!chain) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.sdi = $urandom_range(0, 1);
                    step();
                end
                do_start();
            end
            shift_bits(data, par, drop_at);
            hold_and_accept(delay, next_chain, 1'b1);
            chain = next_chain;
        end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.sdi       = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single_word();
        test_backpressure();
        test_back_to_back();
        test_dropped_start();
        test_reset_mid_shift();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
